// File: rtl/instr_fetch_pkg.sv
// Shared widths, reset instruction value and FSM encoding for the fetch stage.
package instr_fetch_pkg;

    localparam int          DATA_W_DEFAULT    = 16;
    localparam int          ADDR_W_DEFAULT    = 8;
    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0000;

    typedef enum logic {
        RST_WAIT = 1'b0,
        FETCH    = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched word and its PC tag.
// When load and unload are both asserted, load wins and the entry is replaced.
module fetch_skid_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic              unload,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] pc
);

    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W-1:0] pc_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            pc_reg    <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
            pc_reg    <= load_pc;
        end else if (unload) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;
    assign pc    = pc_reg;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues PC to a 1-cycle synchronous instruction memory, captures the
// returned word into IR with its PC tag, and holds one extra word in a skid buffer.
module instruction_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEFAULT,
    parameter int                ADDR_W    = ADDR_W_DEFAULT,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEFAULT)
) (
    input  logic              CLK,
    input  logic              IF_RST,
    input  logic [ADDR_W-1:0] PC,
    output logic              PC_EN,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic              IMEM_RD,
    input  logic [DATA_W-1:0] IMEM_DATA,
    input  logic              IF_STALL,
    input  logic              IF_FLUSH,
    output logic [DATA_W-1:0] IR,
    output logic [ADDR_W-1:0] IR_PC,
    output logic              IR_VALID
);

    fetch_state_t      state_reg, state_next;
    logic              inflight_reg;
    logic [ADDR_W-1:0] inflight_pc_reg;
    logic [DATA_W-1:0] ir_reg, ir_next;
    logic [ADDR_W-1:0] ir_pc_reg, ir_pc_next;
    logic              ir_valid_reg, ir_valid_next;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [ADDR_W-1:0] skid_pc;
    logic              skid_load;
    logic              skid_unload;

    logic              issue;
    logic              consume;
    logic              arrival;

    // The skid blocks issue, so at most one word is ever in flight behind a full skid.
    assign issue   = (state_reg == FETCH) && !IF_FLUSH && !IF_STALL && !skid_valid;
    assign consume = ir_valid_reg && !IF_STALL;
    assign arrival = inflight_reg && !IF_FLUSH;

    assign PC_EN     = issue;
    assign IMEM_RD   = issue;
    assign IMEM_ADDR = PC;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RST_WAIT: state_next = FETCH;
            FETCH:    state_next = FETCH;
            default:  state_next = RST_WAIT;
        endcase
    end

    always_comb begin
        ir_next       = ir_reg;
        ir_pc_next    = ir_pc_reg;
        ir_valid_next = ir_valid_reg;
        skid_load     = 1'b0;
        skid_unload   = 1'b0;

        if (IF_FLUSH) begin
            ir_next       = NOP_INSTR;
            ir_valid_next = 1'b0;
            skid_unload   = 1'b1;
        end else if (arrival) begin
            if (skid_valid && consume) begin
                ir_next       = skid_data;
                ir_pc_next    = skid_pc;
                ir_valid_next = 1'b1;
                skid_load     = 1'b1;
            end else if (!ir_valid_reg || consume) begin
                ir_next       = IMEM_DATA;
                ir_pc_next    = inflight_pc_reg;
                ir_valid_next = 1'b1;
            end else begin
                skid_load = 1'b1;
            end
        end else if (skid_valid && (consume || !ir_valid_reg)) begin
            ir_next       = skid_data;
            ir_pc_next    = skid_pc;
            ir_valid_next = 1'b1;
            skid_unload   = 1'b1;
        end else if (consume) begin
            ir_next       = NOP_INSTR;
            ir_valid_next = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (IF_RST) begin
            state_reg       <= RST_WAIT;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            ir_reg          <= NOP_INSTR;
            ir_pc_reg       <= '0;
            ir_valid_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            inflight_reg    <= issue;
            inflight_pc_reg <= PC;
            ir_reg          <= ir_next;
            ir_pc_reg       <= ir_pc_next;
            ir_valid_reg    <= ir_valid_next;
        end
    end

    fetch_skid_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk       (CLK),
        .srst      (IF_RST),
        .load      (skid_load),
        .unload    (skid_unload),
        .load_data (IMEM_DATA),
        .load_pc   (inflight_pc_reg),
        .valid     (skid_valid),
        .data      (skid_data),
        .pc        (skid_pc)
    );

    assign IR       = ir_reg;
    assign IR_PC    = ir_pc_reg;
    assign IR_VALID = ir_valid_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: PC register and memory modelled around the DUT,
// expected IR stream taken from an ordered queue of words held by the stage.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        IF_RST = 1'b1;
    logic [7:0]  pc;
    logic        PC_EN;
    logic [7:0]  IMEM_ADDR;
    logic        IMEM_RD;
    logic [15:0] imem_data;
    logic        IF_STALL = 1'b0;
    logic        IF_FLUSH = 1'b0;
    logic [15:0] IR;
    logic [7:0]  IR_PC;
    logic        IR_VALID;
    logic [7:0]  flush_target = 8'h00;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference state: words held by the stage in presentation order (IR first).
    logic [7:0] q[$];
    bit         fetch_m  = 1'b0;
    bit         infl_m   = 1'b0;
    logic [7:0] infl_pc_m = 8'h00;
    bit         rst_clean = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (IF_RST)        pc <= 8'h00;
        else if (IF_FLUSH) pc <= flush_target;
        else if (PC_EN)    pc <= pc + 8'h01;
    end

    always @(posedge clk) begin
        if (IMEM_RD) imem_data <= {8'hA5, IMEM_ADDR};
    end

    instruction_fetch dut (
        .CLK       (clk),
        .IF_RST    (IF_RST),
        .PC        (pc),
        .PC_EN     (PC_EN),
        .IMEM_ADDR (IMEM_ADDR),
        .IMEM_RD   (IMEM_RD),
        .IMEM_DATA (imem_data),
        .IF_STALL  (IF_STALL),
        .IF_FLUSH  (IF_FLUSH),
        .IR        (IR),
        .IR_PC     (IR_PC),
        .IR_VALID  (IR_VALID)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
    task automatic step(input bit rst, input bit stall, input bit flush, input logic [7:0] tgt);
        bit exp_issue;
        IF_RST = rst;
        IF_STALL = stall;
        IF_FLUSH = flush;
        flush_target = tgt;
        @(negedge clk);
        exp_issue = fetch_m && !flush && !stall && (q.size() < 2);
        check("pc_en", {31'd0, PC_EN}, {31'd0, exp_issue});
        check("imem_rd", {31'd0, IMEM_RD}, {31'd0, exp_issue});
        check("imem_addr", {24'd0, IMEM_ADDR}, {24'd0, pc});
        check("ir_valid", {31'd0, IR_VALID}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            check("ir", {16'd0, IR}, {16'd0, 8'hA5, q[0]});
            check("ir_pc", {24'd0, IR_PC}, {24'd0, q[0]});
        end else begin
            check("ir_nop", {16'd0, IR}, 32'h0);
            if (rst_clean) check("ir_pc_rst", {24'd0, IR_PC}, 32'h0);
        end
        $display("cyc rst=%0b stall=%0b flush=%0b pc=%02h pc_en=%0b ir_valid=%0b ir=%04h ir_pc=%02h",
                 rst, stall, flush, pc, PC_EN, IR_VALID, IR, IR_PC);
        if (rst) begin
            q.delete();
            infl_m = 1'b0;
            fetch_m = 1'b0;
            rst_clean = 1'b1;
        end else begin
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && !stall) void'(q.pop_front());
                if (infl_m) q.push_back(infl_pc_m);
            end
            infl_m = exp_issue;
            infl_pc_m = pc;
            fetch_m = 1'b1;
            if (q.size() > 0) rst_clean = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;

        // Reset state and release: first valid word A500 three cycles after release.
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 40 && !(q.size() > 0 && q[0] == 8'h04); i++) step(0, 0, 0, 8'h00);
        check("reach_a504", {31'd0, (q.size() > 0 && q[0] == 8'h04)}, 32'd1);

        // Stall three cycles with A504 in IR; A505 lands in the skid.
        repeat (3) step(0, 1, 0, 8'h00);
        repeat (6) step(0, 0, 0, 8'h00);

        // Flush to CB while A510 is in flight.
        for (int i = 0; i < 40 && !(infl_m && infl_pc_m == 8'h10); i++) step(0, 0, 0, 8'h00);
        check("reach_a510_inflight", {31'd0, (infl_m && infl_pc_m == 8'h10)}, 32'd1);
        step(0, 0, 1, 8'hCB);
        repeat (6) step(0, 0, 0, 8'h00);

        // Flush together with stall while the skid is full.
        for (int i = 0; i < 10 && q.size() != 2; i++) step(0, 1, 0, 8'h00);
        check("skid_full_1", q.size(), 32'd2);
        step(0, 1, 1, 8'h29);
        repeat (6) step(0, 0, 0, 8'h00);

        // Sequential fetch across the FF -> 00 wrap.
        step(0, 0, 1, 8'hFD);
        repeat (8) step(0, 0, 0, 8'h00);

        // Reset while the skid holds a word, then a full release sequence.
        for (int i = 0; i < 10 && q.size() != 2; i++) step(0, 1, 0, 8'h00);
        check("skid_full_2", q.size(), 32'd2);
        step(1, 1, 0, 8'h00);
        repeat (8) step(0, 0, 0, 8'h00);

        // Randomized stall / flush / reset traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 5,
                 8'($urandom));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly downstream of the program counter in the 16-bit RISC computer. It drives the PC value as the address of a synchronous-read instruction memory with 1-cycle latency. It captures the returned word into the instruction register (IR) with its PC tag, and presents it to decode with a valid/stall handshake. It owns PC_EN, advancing the PC only when a fetch is issued. A one-entry skid buffer absorbs the in-flight word when decode stalls.

Parameters:
DATA_W, 16, instruction width
ADDR_W, 8, instruction address / PC width
NOP_INSTR, 16'h0000, IR value whenever IR_VALID=0 and after reset

Ports:
CLK  in  1  rising-edge clock
IF_RST  in  1  synchronous active-high reset
PC  in  ADDR_W  current program counter
PC_EN  out  1  advance PC at this edge (=issue)
IMEM_ADDR  out  ADDR_W  instruction memory address (=PC)
IMEM_RD  out  1  read strobe (=issue)
IMEM_DATA  in  DATA_W  read data, valid the cycle after IMEM_RD
IF_STALL  in  1  decode cannot accept IR this cycle
IF_FLUSH  in  1  branch/jump taken; PC_LD is asserted at the same edge
IR  out  DATA_W  instruction register
IR_PC  out  ADDR_W  address IR was fetched from
IR_VALID  out  1  IR holds a live instruction

Behaviour:
- Reset: while IF_RST=1 at an edge, state<=RST_WAIT, IR<=NOP_INSTR, IR_PC<=0, IR_VALID<=0, skid empty, inflight<=0. PC_EN and IMEM_RD are 0 while in RST_WAIT.
- FSM: RST_WAIT -> FETCH after exactly one cycle with IF_RST=0. This gives the PC one cycle to settle after its own reset. FETCH persists until IF_RST.
- issue = (state==FETCH) & !IF_FLUSH & !IF_STALL & !SKID_VALID. IMEM_ADDR=PC at all times. PC_EN=IMEM_RD=issue, combinational.
- inflight<=issue and inflight_pc<=PC, registered.
- Consume: an edge with IR_VALID=1 and IF_STALL=0 hands IR to decode.
- Data arrival (inflight=1, no flush) routes the word by priority:
  - If the skid is valid and the IR is consumed: IR<=skid, and the new word goes into the skid. This case cannot occur, because issue is blocked while the skid is valid; it is listed for completeness.
  - If IR_VALID=0 or the IR is consumed: IR<=IMEM_DATA, IR_PC<=inflight_pc, IR_VALID<=1.
  - Otherwise (stalled with a full IR): SKID<=IMEM_DATA with its PC, SKID_VALID<=1.
- No arrival, skid valid, IR consumed or empty: IR<=SKID, SKID_VALID<=0.
- No arrival, nothing pending, IR consumed: IR_VALID<=0, IR<=NOP_INSTR.
- Flush overrides stall and arrival. At the edge: IR_VALID<=0, IR<=NOP_INSTR, SKID_VALID<=0, inflight<=0 (in-flight word discarded), and no issue that cycle, so PC_EN=0 and the PC loads PC_NEXT via PC_LD. Fetch resumes from the new PC on the next cycle.
- Latency: issue at cycle n -> IR_VALID with that word at cycle n+2. Throughput is 1 instr/cycle when unstalled.
- Ordering is strictly preserved; no instruction is duplicated or dropped except on flush.
- PC wrap 8'hFF->8'h00 is the PC's concern. IR_PC carries the wrapped value unchanged.
- IF_RST mid-stall or mid-flight: the reset wins and all state is cleared as above.
- Invariant: at most one word in flight plus one in the skid; the skid never overflows.

Decomposition:
- Package instr_fetch_pkg: DATA_W/ADDR_W defaults, NOP_INSTR, state encoding (RST_WAIT, FETCH).
- Sub-module fetch_skid_buffer: the one-entry data+PC holding register with valid/load/unload.

Test Plan:
- Reset release, mem[a]={8'hA5,a}, no stall: PC_EN=0 the cycle after IF_RST falls, then 1. IR_VALID rises 3 cycles after reset release with IR=16'hA500, IR_PC=0. Then 16'hA501, 16'hA502… on consecutive cycles.
- Stall for 3 cycles while IR=16'hA504: IR holds 16'hA504; the in-flight 16'hA505 goes to the skid; PC_EN=0 during the stall. On release, IR=16'hA505 next cycle, then 16'hA506 with no gap beyond one refill cycle and no duplicates.
- Flush with the PC loaded to 8'hCB while 16'hA510 is in flight: IR_VALID=0 the next cycle, 16'hA510 is never presented, next valid IR=16'hA5CB with IR_PC=8'hCB.
- Flush and stall asserted together with the skid full: both the IR and the skid are cleared; fetch resumes from the loaded PC 8'h29.
- Sequential fetch through 8'hFE, 8'hFF, 8'h00: IR_PC follows the PC and wraps correctly.
- IF_RST asserted while the skid is valid: IR_VALID=0, IR=NOP_INSTR, and a full reset-release sequence repeats from PC=0.
